if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction fetch stage of the 5-stage MIPS pipeline, directly upstream of decode.
- Owns the PC and issues word fetches to instruction memory over a request/grant + response-valid handshake.
- Feeds the IF/ID register (instruction word + PC) consumed by the decoder.
- Handles decode back-pressure (stall) and EX-stage redirects (branch/jump/JR) with flush, inserting NOP (32'h0000_0000) bubbles.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.

Ports:
clk  input  1  pipeline clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch byte address, word aligned.
imem_gnt  input  1  request accepted this cycle (when imem_req=1).
imem_rvalid  input  1  response data valid; exactly one per granted request, at least 1 cycle after grant.
imem_rdata  input  32  instruction word.
redirect_valid  input  1  EX-stage redirect (taken branch, J/JAL, JR).
redirect_pc  input  32  redirect target.
id_stall  input  1  decode cannot accept; IF/ID holds.
id_valid  output  1  IF/ID holds a real instruction.
id_ins  output  32  instruction word; NOP when id_valid=0.
id_pc  output  32  address of id_ins.
id_early_jmp  output  1  instruction was already redirected in fetch (see Optional Feature); constant 0 when feature off.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=REQ, imem_req=0, imem_addr=RESET_PC.
  - id_valid=0, id_ins=NOP, id_pc=0, id_early_jmp=0, skid buffer empty.
- imem_req and imem_addr are registered. imem_req=1 only in state REQ, with imem_addr=pc. Only one request is outstanding at a time.
- FSM states: REQ, WAIT, HOLD, DROP.
  - REQ: on imem_gnt, go to WAIT and latch fetch_pc=pc. With no grant, stay in REQ and hold the address stable.
  - WAIT: on imem_rvalid with IF/ID free (id_valid=0 or id_stall=0), load IF/ID (id_ins=imem_rdata, id_pc=fetch_pc, id_valid=1), set pc=fetch_pc+4 (mod 2^32, wraps), and go to REQ. If IF/ID is not free, write the word into the skid buffer and go to HOLD.
  - HOLD: when id_stall=0, move the skid buffer into IF/ID, set pc=fetch_pc+4, and go to REQ.
  - DROP: discard the next imem_rvalid (no IF/ID write), then go to REQ.
- id_stall=1: IF/ID registers hold. id_stall=0 with nothing new to load: id_valid<=0, id_ins<=NOP.
- Redirect (highest priority, any state):
  - Set pc<=redirect_pc.
  - Flush IF/ID (id_valid<=0, id_ins<=NOP, id_early_jmp<=0), including when id_stall=1.
  - Clear the skid buffer.
  - Next state: DROP if a request is outstanding (WAIT, or REQ with imem_gnt in the same cycle), otherwise REQ.
  - A same-cycle imem_rvalid is discarded.
- Throughput: with 1-cycle memory latency and no stalls, one instruction every 2 cycles. No instruction is lost or duplicated under any stall/redirect mix.
- No branch delay slot: after a redirect, the first instruction delivered is the one at redirect_pc.
- imem_addr[1:0] is always 2'b00. A misaligned redirect_pc is forced aligned (low 2 bits cleared).

Optional Feature:
Macro IF_EARLY_JUMP_EN.
- Defined: when a word is loaded into IF/ID with opcode[31:26]=6'b000010 (J) or 6'b000011 (JAL):
  - pc<=target = {fetch_pc+4 [31:28], ins[25:0], 2'b00} instead of fetch_pc+4.
  - id_early_jmp<=1; EX must suppress its own redirect for that instruction.
  - An external redirect in the same cycle overrides the early target.
- Undefined: opcode is not inspected, pc advances by 4, id_early_jmp tied to 0.

Test Plan:
1. RESET_PC=32'h0000_3000, release rst_n -> imem_req=1, imem_addr=32'h3000 on the first edge after release; id_valid=0, id_ins=0 throughout reset.
2. Immediate gnt, rvalid next cycle with 32'h2008_0005 -> id_valid=1, id_ins=32'h20080005, id_pc=32'h3000; next imem_addr=32'h3004.
3. id_stall=1 for 5 cycles while response 32'h0109_5020 arrives -> state HOLD, IF/ID unchanged; after release the word appears once with id_pc=32'h3004 and the next fetch is 32'h3008.
4. redirect_valid=1, redirect_pc=32'h4000 while in WAIT -> IF/ID flushed next cycle, old response dropped, next imem_addr=32'h4000; pc=32'hFFFF_FFFC fetch -> next imem_addr=32'h0.
5. redirect_valid=1 and id_stall=1 in the same cycle, with rvalid also high -> id_valid=0, id_ins=NOP, the rvalid word is never delivered.
6. Fetch 32'h0800_0010 at pc 32'h3000 -> with IF_EARLY_JUMP_EN: next imem_addr=32'h0000_0040, id_early_jmp=1; without: next imem_addr=32'h3004, id_early_jmp=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage for the 5-stage MIPS pipeline.
// Owns the PC, issues single-outstanding word fetches over a req/gnt + rvalid
// handshake and fills the IF/ID register consumed by decode. Handles decode
// back-pressure through a one-word skid buffer and EX redirects with flush.
// Optional feature: define IF_EARLY_JUMP_EN to resolve J/JAL targets in fetch.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_ins,
  output logic [31:0] id_pc,
  output logic        id_early_jmp
);

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold,
    StDrop
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] skid_q;

  logic        if_id_free;
  logic        load;
  logic [31:0] load_word;
  logic [31:0] seq_pc;
  logic        early_hit;
  logic [31:0] load_next_pc;
  logic        outstanding;
  logic [31:0] redirect_aligned;

  // The PC register doubles as the registered fetch address.
  assign imem_addr = pc_q;

  // Decode of the current cycle: what IF/ID receives and where fetch goes next.
  always_comb begin
    if_id_free       = !id_valid || !id_stall;
    load             = ((state_q == StWait) && imem_rvalid && if_id_free) ||
                       ((state_q == StHold) && !id_stall);
    load_word        = (state_q == StHold) ? skid_q : imem_rdata;
    seq_pc           = fetch_pc_q + 32'd4;
    redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
`ifdef IF_EARLY_JUMP_EN
    // J (000010) and JAL (000011) differ only in opcode bit 26.
    early_hit        = (load_word[31:27] == 5'b00001);
    load_next_pc     = early_hit ? {seq_pc[31:28], load_word[25:0], 2'b00} : seq_pc;
`else
    early_hit        = 1'b0;
    load_next_pc     = seq_pc;
`endif
    // A response arriving in the same cycle as the redirect retires the request,
    // and a granted request can never respond in its grant cycle.
    outstanding      = (((state_q == StWait) || (state_q == StDrop)) && !imem_rvalid) ||
                       ((state_q == StReq) && imem_req && imem_gnt);
  end

  // Fetch FSM, PC, skid buffer and the IF/ID register, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      skid_q       <= NOP;
      imem_req     <= 1'b0;
      id_valid     <= 1'b0;
      id_ins       <= NOP;
      id_pc        <= 32'h0000_0000;
      id_early_jmp <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over everything, including stall and a same-cycle response.
      pc_q         <= redirect_aligned;
      skid_q       <= NOP;
      id_valid     <= 1'b0;
      id_ins       <= NOP;
      id_early_jmp <= 1'b0;
      if (outstanding) begin
        state_q  <= StDrop;
        imem_req <= 1'b0;
      end else begin
        state_q  <= StReq;
        imem_req <= 1'b1;
      end
    end else begin
      if (load) begin
        id_valid     <= 1'b1;
        id_ins       <= load_word;
        id_pc        <= fetch_pc_q;
        id_early_jmp <= early_hit;
      end else if (!id_stall) begin
        id_valid     <= 1'b0;
        id_ins       <= NOP;
        id_early_jmp <= 1'b0;
      end

      if (load) begin
        pc_q     <= load_next_pc;
        state_q  <= StReq;
        imem_req <= 1'b1;
      end else begin
        unique case (state_q)
          StReq: begin
            if (imem_req && imem_gnt) begin
              state_q    <= StWait;
              fetch_pc_q <= pc_q;
              imem_req   <= 1'b0;
            end else begin
              imem_req <= 1'b1;
            end
          end
          StWait: begin
            // Reaching here with a response means IF/ID is blocked.
            if (imem_rvalid) begin
              skid_q  <= imem_rdata;
              state_q <= StHold;
            end
          end
          StHold: begin
            // Waiting for decode to release the stall.
          end
          StDrop: begin
            if (imem_rvalid) begin
              state_q  <= StReq;
              imem_req <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a randomized
// run against a program-order reference model of the delivered stream.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_ins;
  logic [31:0] id_pc;
  logic        id_early_jmp;

  int tests_run;
  int tests_failed;

  if_fetch_stage #(
    .RESET_PC(RST_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_stall      (id_stall),
    .id_valid      (id_valid),
    .id_ins        (id_ins),
    .id_pc         (id_pc),
    .id_early_jmp  (id_early_jmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: a scrambled word per address, with a sprinkling of J/JAL.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E37_79B1 + 32'h7F4A_7C15;
    h = h ^ (h >> 15);
    if (h[31:27] == 5'b00001) h[29] = 1'b1;
    if (h[4:0] == 5'd0) h[31:26] = {5'b00001, h[5]};
    return h;
  endfunction

  function automatic logic is_jump(input logic [31:0] w);
    return (w[31:26] == 6'b000010) || (w[31:26] == 6'b000011);
  endfunction

  // Program order: the address of the instruction after word w at address p.
  function automatic logic [31:0] next_pc_of(input logic [31:0] p, input logic [31:0] w);
    logic [31:0] p4;
    p4 = p + 32'd4;
`ifdef IF_EARLY_JUMP_EN
    if (is_jump(w)) return {p4[31:28], w[25:0], 2'b00};
`endif
    return p4;
  endfunction

  function automatic logic exp_early(input logic [31:0] w);
`ifdef IF_EARLY_JUMP_EN
    return is_jump(w);
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_inputs();
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_stall       = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async_req: got %b want 0", imem_req);
    end
    @(negedge clk);
    tests_run++;
    if (imem_addr !== RST_PC || id_valid !== 1'b0 || id_ins !== 32'h0 || id_pc !== 32'h0 ||
        id_early_jmp !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: addr=%h v=%b ins=%h pc=%h ej=%b want %h 0 0 0 0",
               imem_addr, id_valid, id_ins, id_pc, id_early_jmp, RST_PC);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC || id_valid !== 1'b0 || id_ins !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_release: req=%b addr=%h v=%b ins=%h want 1 %h 0 0",
               imem_req, imem_addr, id_valid, id_ins, RST_PC);
    end
  endtask

  task automatic test_basic_fetch();
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    tests_run++;
    if (imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_req_drop: got %b want 0", imem_req);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2008_0005;
    @(negedge clk);
    imem_rvalid = 1'b0;
    tests_run++;
    if (id_valid !== 1'b1 || id_ins !== 32'h2008_0005 || id_pc !== 32'h3000 ||
        imem_req !== 1'b1 || imem_addr !== 32'h3004) begin
      tests_failed++;
      $display("FAIL basic_fetch: v=%b ins=%h pc=%h req=%b addr=%h want 1 20080005 3000 1 3004",
               id_valid, id_ins, id_pc, imem_req, imem_addr);
    end
  endtask

  task automatic test_stall_hold();
    id_stall = 1'b1;
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0109_5020;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hA5A5_A5A5;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (id_valid !== 1'b1 || id_ins !== 32'h2008_0005 || id_pc !== 32'h3000 ||
          imem_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: v=%b ins=%h pc=%h req=%b want 1 20080005 3000 0",
                 i, id_valid, id_ins, id_pc, imem_req);
      end
      @(negedge clk);
    end
    id_stall = 1'b0;
    @(negedge clk);
    tests_run++;
    if (id_valid !== 1'b1 || id_ins !== 32'h0109_5020 || id_pc !== 32'h3004 ||
        imem_req !== 1'b1 || imem_addr !== 32'h3008) begin
      tests_failed++;
      $display("FAIL stall_release: v=%b ins=%h pc=%h req=%b addr=%h want 1 01095020 3004 1 3008",
               id_valid, id_ins, id_pc, imem_req, imem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (id_valid !== 1'b0 || id_ins !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h3008)
    begin
      tests_failed++;
      $display("FAIL stall_once: v=%b ins=%h req=%b addr=%h want 0 0 1 3008",
               id_valid, id_ins, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4000;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests_run++;
    if (id_valid !== 1'b0 || id_ins !== 32'h0 || imem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL redir_wait_flush: v=%b ins=%h req=%b want 0 0 0", id_valid, id_ins, imem_req);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    tests_run++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4000) begin
      tests_failed++;
      $display("FAIL redir_wait_drop: v=%b req=%b addr=%h want 0 1 4000",
               id_valid, imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    @(negedge clk);
    imem_rvalid = 1'b0;
    tests_run++;
    if (id_valid !== 1'b1 || id_ins !== 32'h1111_1111 || id_pc !== 32'h4000 ||
        imem_addr !== 32'h4004) begin
      tests_failed++;
      $display("FAIL redir_target_first: v=%b ins=%h pc=%h addr=%h want 1 11111111 4000 4004",
               id_valid, id_ins, id_pc, imem_addr);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || id_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_align: req=%b addr=%h v=%b want 1 fffffffc 0",
               imem_req, imem_addr, id_valid);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2222_2222;
    @(negedge clk);
    imem_rvalid = 1'b0;
    tests_run++;
    if (id_pc !== 32'hFFFF_FFFC || id_ins !== 32'h2222_2222 || imem_req !== 1'b1 ||
        imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_next: pc=%h ins=%h req=%b addr=%h want fffffffc 22222222 1 0",
               id_pc, id_ins, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_stall_rvalid();
    id_stall = 1'b1;
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h3333_3333;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_5000;
    @(negedge clk);
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    tests_run++;
    if (id_valid !== 1'b0 || id_ins !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h5000)
    begin
      tests_failed++;
      $display("FAIL redir_stall_flush: v=%b ins=%h req=%b addr=%h want 0 0 1 5000",
               id_valid, id_ins, imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    tests_run++;
    if (id_valid !== 1'b0 || id_ins !== 32'h0) begin
      tests_failed++;
      $display("FAIL redir_stall_nodeliver: v=%b ins=%h want 0 0", id_valid, id_ins);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h4444_4444;
    @(negedge clk);
    imem_rvalid = 1'b0;
    tests_run++;
    if (id_valid !== 1'b1 || id_ins !== 32'h4444_4444 || id_pc !== 32'h5000) begin
      tests_failed++;
      $display("FAIL redir_stall_next: v=%b ins=%h pc=%h want 1 44444444 5000",
               id_valid, id_ins, id_pc);
    end
    id_stall = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_early_jump();
    logic [31:0] want_addr;
    logic [31:0] want_pc;
    logic        want_ej;
    do_reset();
    @(negedge clk);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0800_0010;
    @(negedge clk);
    imem_rvalid = 1'b0;
`ifdef IF_EARLY_JUMP_EN
    want_addr = 32'h0000_0040;
    want_ej   = 1'b1;
`else
    want_addr = 32'h0000_3004;
    want_ej   = 1'b0;
`endif
    tests_run++;
    if (id_ins !== 32'h0800_0010 || id_pc !== 32'h3000 || id_early_jmp !== want_ej ||
        imem_addr !== want_addr) begin
      tests_failed++;
      $display("FAIL early_j: ins=%h pc=%h ej=%b addr=%h want 08000010 3000 %b %h",
               id_ins, id_pc, id_early_jmp, imem_addr, want_ej, want_addr);
    end
    want_pc  = want_addr;
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0C00_0100;
    @(negedge clk);
    imem_rvalid = 1'b0;
`ifdef IF_EARLY_JUMP_EN
    want_addr = 32'h0000_0400;
`else
    want_addr = 32'h0000_3008;
`endif
    tests_run++;
    if (id_ins !== 32'h0C00_0100 || id_pc !== want_pc || id_early_jmp !== want_ej ||
        imem_addr !== want_addr) begin
      tests_failed++;
      $display("FAIL early_jal: ins=%h pc=%h ej=%b addr=%h want 0c000100 %h %b %h",
               id_ins, id_pc, id_early_jmp, imem_addr, want_pc, want_ej, want_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    int          idle;
    int          consumed;
    logic        prev_hold;
    logic [31:0] prev_addr;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] w;
    do_reset();
    exp_pc    = RST_PC;
    pend      = 1'b0;
    cnt       = 0;
    paddr     = 32'h0;
    idle      = 0;
    consumed  = 0;
    prev_hold = 1'b0;
    prev_addr = 32'h0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      tests_run++;
      if (!id_valid && id_ins !== 32'h0) begin
        tests_failed++;
        $display("FAIL rnd_nop_when_invalid: ins=%h want 0 (cycle %0d)", id_ins, c);
      end
      tests_run++;
      if (imem_addr[1:0] !== 2'b00) begin
        tests_failed++;
        $display("FAIL rnd_addr_aligned: addr=%h (cycle %0d)", imem_addr, c);
      end
      tests_run++;
      if (imem_req && pend) begin
        tests_failed++;
        $display("FAIL rnd_one_outstanding: req while pending (cycle %0d)", c);
      end
      if (prev_hold) begin
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          tests_failed++;
          $display("FAIL rnd_addr_stable: req=%b addr=%h want 1 %h (cycle %0d)",
                   imem_req, imem_addr, prev_addr, c);
        end
      end
      id_stall = ($urandom % 4 == 0);
      redir    = ($urandom % 24 == 0);
      if ($urandom % 6 == 0) rpc = 32'hFFFF_FFF4 + ($urandom % 4);
      else rpc = 32'h0000_3000 + (($urandom % 256) << 2) + ($urandom % 4);
      redirect_valid = redir;
      redirect_pc    = rpc;
      imem_rvalid    = 1'b0;
      imem_rdata     = $urandom;
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
        end else begin
          cnt--;
        end
      end
      imem_gnt = imem_req && !pend && ($urandom % 3 != 0);
      if (imem_rvalid) pend = 1'b0;
      if (imem_gnt) begin
        pend  = 1'b1;
        cnt   = $urandom % 3;
        paddr = imem_addr;
      end
      prev_hold = imem_req && !imem_gnt && !redir;
      prev_addr = imem_addr;
      // Decode takes IF/ID at the coming edge; a redirect then restarts the stream.
      if (id_valid && !id_stall) begin
        w = mem_word(exp_pc);
        tests_run++;
        if (id_pc !== exp_pc || id_ins !== w || id_early_jmp !== exp_early(w)) begin
          tests_failed++;
          $display("FAIL rnd_stream: pc=%h ins=%h ej=%b want %h %h %b (cycle %0d)",
                   id_pc, id_ins, id_early_jmp, exp_pc, w, exp_early(w), c);
        end
        exp_pc = next_pc_of(exp_pc, w);
        consumed++;
        idle = 0;
      end else begin
        idle++;
      end
      if (redir) exp_pc = rpc & 32'hFFFF_FFFC;
      if (idle > 300) begin
        tests_run++;
        tests_failed++;
        $display("FAIL rnd_liveness: no instruction delivered for %0d cycles", idle);
        break;
      end
    end
    tests_run++;
    if (consumed < 300) begin
      tests_failed++;
      $display("FAIL rnd_throughput: delivered %0d want at least 300", consumed);
    end
    idle_inputs();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_fetch();
    test_stall_hold();
    test_redirect_wait();
    test_wrap();
    test_redirect_stall_rvalid();
    test_early_jump();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
